queue_enq_arbiter: RTL and testbench

Round-robin arbiter that shares the enqueue port of one register-based normal queue among `num_reqs` requesters using en/rdy handshakes. Each cycle it selects at most one valid requester and forwards that requester's message to the queue with zero added latency. An optional burst lock grants the same requester up to `max_burst` back-to-back transfers. It sits between producer ports and the shared queue's `enq_en`/`enq_rdy`/`enq_msg`.

---
 rtl/queue_enq_arbiter.sv | 141 ++++++++++++++
 tb/tb_queue_enq_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/queue_enq_arbiter.sv
// queue_enq_arbiter: round-robin arbiter sharing one queue enqueue port among
// num_reqs en/rdy producers, with an optional burst lock (max_burst > 1).
// Optional statistics counters are built when QUEUE_ENQ_ARB_STATS_EN is defined.
//
// Handshake: requester i transfers in a cycle exactly when reqs_val[i] and
// reqs_rdy[i] are both high; reqs_rdy is one-hot or zero, never depends on a
// requester other than the granted one, and q_enq_en mirrors that transfer.
module queue_enq_arbiter #(
  parameter int data_width = 32,
  parameter int num_reqs   = 4,
  parameter int max_burst  = 1,
  parameter int idx_width  = $clog2(num_reqs)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [num_reqs-1:0]              reqs_val,
  output logic [num_reqs-1:0]              reqs_rdy,
  input  logic [num_reqs*data_width-1:0]   reqs_msg,
  output logic                             q_enq_en,
  input  logic                             q_enq_rdy,
  output logic [data_width-1:0]            q_enq_msg,
`ifdef QUEUE_ENQ_ARB_STATS_EN
  output logic [31:0]                      stall_cnt,
  output logic [31:0]                      xfer_cnt,
`endif
  output logic [idx_width-1:0]             grant_idx
);

  localparam int cnt_width = $clog2(max_burst + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state;
  logic [idx_width-1:0] prio_ptr;
  logic [idx_width-1:0] owner;
  logic [cnt_width-1:0] burst_cnt;

  logic                 rr_found;
  logic [idx_width-1:0] rr_idx;
  logic                 lock_hold;
  logic                 gnt_valid;
  logic [idx_width-1:0] gnt_idx;
  logic                 xfer;

  // Round-robin search starting at prio_ptr, wrapping past num_reqs-1 to 0.
  always_comb begin
    logic [idx_width:0] cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 0; k < num_reqs; k++) begin
      cand = {1'b0, prio_ptr} + (idx_width+1)'(k);
      if (cand >= (idx_width+1)'(num_reqs)) cand = cand - (idx_width+1)'(num_reqs);
      if (!rr_found && reqs_val[cand[idx_width-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[idx_width-1:0];
      end
    end
  end

  // Grant selection: a live lock pins the owner, otherwise round-robin wins.
  always_comb begin
    lock_hold = (state == LOCKED) && reqs_val[owner];
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (!reset && q_enq_rdy) begin
      if (lock_hold) begin
        gnt_valid = 1'b1;
        gnt_idx   = owner;
      end else if (rr_found) begin
        gnt_valid = 1'b1;
        gnt_idx   = rr_idx;
      end
    end
  end

  // Output datapath: one-hot ready, strobe and message mux of the winner.
  always_comb begin
    reqs_rdy  = '0;
    q_enq_msg = '0;
    for (int k = 0; k < num_reqs; k++) begin
      if (gnt_valid && gnt_idx == idx_width'(k)) begin
        reqs_rdy[k] = 1'b1;
        q_enq_msg   = reqs_msg[k*data_width +: data_width];
      end
    end
    q_enq_en  = |(reqs_val & reqs_rdy);
    xfer      = q_enq_en;
    grant_idx = gnt_valid ? gnt_idx : '0;
  end

  // Arbiter state: priority pointer, burst owner/count and IDLE/LOCKED FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio_ptr  <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else if (lock_hold) begin
      // Owner still valid: count its transfers, hold everything on backpressure.
      if (xfer) begin
        if (burst_cnt + cnt_width'(1) == cnt_width'(max_burst)) begin
          state     <= IDLE;
          burst_cnt <= '0;
        end else begin
          burst_cnt <= burst_cnt + cnt_width'(1);
        end
      end
    end else if (xfer) begin
      // IDLE, or a lock broken by its owner dropping valid: plain arbitration.
      prio_ptr <= (gnt_idx == idx_width'(num_reqs - 1)) ? '0 : gnt_idx + idx_width'(1);
      if (max_burst > 1) begin
        state     <= LOCKED;
        owner     <= gnt_idx;
        burst_cnt <= cnt_width'(1);
      end else begin
        state     <= IDLE;
        burst_cnt <= '0;
      end
    end else begin
      state     <= IDLE;
      burst_cnt <= '0;
    end
  end

`ifdef QUEUE_ENQ_ARB_STATS_EN
  // Saturating counters of stalled-demand cycles and transfer cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      if ((|reqs_val) && !q_enq_rdy && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (q_enq_en && xfer_cnt != 32'hFFFF_FFFF)
        xfer_cnt <= xfer_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Testbench for queue_enq_arbiter: two instances (max_burst 1 and 3) share
// the same stimulus; a hand-derived vector table covers the directed cases
// and a queue-free reference model checks every cycle, including random runs.
module tb_queue_enq_arbiter;

  localparam int dw = 32;
  localparam int nr = 4;
  localparam int iw = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [nr-1:0]     reqs_val = '0;
  logic              q_enq_rdy = 1'b0;
  logic [nr*dw-1:0]  reqs_msg = '0;
  logic [dw-1:0]     msg_arr [nr];

  logic [nr-1:0] rdy_rr, rdy_bu;
  logic          en_rr, en_bu;
  logic [dw-1:0] qmsg_rr, qmsg_bu;
  logic [iw-1:0] gidx_rr, gidx_bu;
`ifdef QUEUE_ENQ_ARB_STATS_EN
  logic [31:0] stall_rr, xfer_rr, stall_bu, xfer_bu;
`endif

  queue_enq_arbiter #(.data_width(dw), .num_reqs(nr), .max_burst(1)) dut_rr (
    .clk(clk), .reset(reset), .reqs_val(reqs_val), .reqs_rdy(rdy_rr),
    .reqs_msg(reqs_msg), .q_enq_en(en_rr), .q_enq_rdy(q_enq_rdy),
    .q_enq_msg(qmsg_rr),
`ifdef QUEUE_ENQ_ARB_STATS_EN
    .stall_cnt(stall_rr), .xfer_cnt(xfer_rr),
`endif
    .grant_idx(gidx_rr)
  );

  queue_enq_arbiter #(.data_width(dw), .num_reqs(nr), .max_burst(3)) dut_bu (
    .clk(clk), .reset(reset), .reqs_val(reqs_val), .reqs_rdy(rdy_bu),
    .reqs_msg(reqs_msg), .q_enq_en(en_bu), .q_enq_rdy(q_enq_rdy),
    .q_enq_msg(qmsg_bu),
`ifdef QUEUE_ENQ_ARB_STATS_EN
    .stall_cnt(stall_bu), .xfer_cnt(xfer_bu),
`endif
    .grant_idx(gidx_bu)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // lock_left = grants the current owner may still take back-to-back (0 = no lock).
  int mb        [2] = '{1, 3};
  int m_ptr     [2] = '{0, 0};
  int m_owner   [2] = '{0, 0};
  int m_left    [2] = '{0, 0};
  int m_stall   [2] = '{0, 0};
  int m_xfer    [2] = '{0, 0};

  function automatic int model_grant(input int k, input logic [nr-1:0] v,
                                     input logic q, input logic r);
    if (r || !q) return -1;
    if (m_left[k] > 0 && v[m_owner[k]]) return m_owner[k];
    for (int j = 0; j < nr; j++) begin
      int c;
      c = (m_ptr[k] + j) % nr;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_update(input int k, input logic [nr-1:0] v,
                              input logic q, input logic r, input int g);
    if (r) begin
      m_ptr[k] = 0; m_owner[k] = 0; m_left[k] = 0;
      m_stall[k] = 0; m_xfer[k] = 0;
    end else begin
      if (v != 0 && !q) m_stall[k]++;
      if (g >= 0) m_xfer[k]++;
      if (m_left[k] > 0 && v[m_owner[k]]) begin
        if (g >= 0) m_left[k]--;
      end else if (g >= 0) begin
        m_ptr[k]   = (g + 1) % nr;
        m_owner[k] = g;
        m_left[k]  = mb[k] - 1;
      end else begin
        m_left[k] = 0;
      end
    end
  endtask

  function automatic logic [nr-1:0] onehot(input int g);
    logic [nr-1:0] o;
    o = '0;
    if (g >= 0) o[g] = 1'b1;
    return o;
  endfunction

  function automatic logic [dw-1:0] exp_msg(input int g);
    if (g < 0) return '0;
    return msg_arr[g];
  endfunction

  // ---------------- driver: one cycle of stimulus + checks ----------------
  task automatic step(input logic r, input logic [nr-1:0] v, input logic q,
                      input bit use_tab, input int exp_rr, input int exp_bu,
                      input int tag);
    int g_rr, g_bu;
    @(negedge clk);
    reset     = r;
    reqs_val  = v;
    q_enq_rdy = q;
    for (int i = 0; i < nr; i++) begin
      msg_arr[i] = $urandom;
      reqs_msg[i*dw +: dw] = msg_arr[i];
    end
    #1;
    g_rr = model_grant(0, v, q, r);
    g_bu = model_grant(1, v, q, r);
    if (use_tab) begin
      check($sformatf("tab%0d_rr_rdy", tag), 32'(rdy_rr), 32'(onehot(exp_rr)));
      check($sformatf("tab%0d_bu_rdy", tag), 32'(rdy_bu), 32'(onehot(exp_bu)));
      check($sformatf("tab%0d_rr_msg", tag), qmsg_rr, exp_msg(exp_rr));
      check($sformatf("tab%0d_bu_idx", tag), 32'(gidx_bu), (exp_bu < 0) ? 32'd0 : 32'(exp_bu));
    end
    check($sformatf("c%0d_rr_rdy", tag), 32'(rdy_rr), 32'(onehot(g_rr)));
    check($sformatf("c%0d_rr_en", tag),  32'(en_rr),  32'(g_rr >= 0));
    check($sformatf("c%0d_rr_msg", tag), qmsg_rr, exp_msg(g_rr));
    check($sformatf("c%0d_rr_idx", tag), 32'(gidx_rr), (g_rr < 0) ? 32'd0 : 32'(g_rr));
    check($sformatf("c%0d_bu_rdy", tag), 32'(rdy_bu), 32'(onehot(g_bu)));
    check($sformatf("c%0d_bu_en", tag),  32'(en_bu),  32'(g_bu >= 0));
    check($sformatf("c%0d_bu_msg", tag), qmsg_bu, exp_msg(g_bu));
    check($sformatf("c%0d_bu_idx", tag), 32'(gidx_bu), (g_bu < 0) ? 32'd0 : 32'(g_bu));
`ifdef QUEUE_ENQ_ARB_STATS_EN
    check($sformatf("c%0d_rr_stall", tag), stall_rr, 32'(m_stall[0]));
    check($sformatf("c%0d_rr_xfer", tag),  xfer_rr,  32'(m_xfer[0]));
    check($sformatf("c%0d_bu_stall", tag), stall_bu, 32'(m_stall[1]));
    check($sformatf("c%0d_bu_xfer", tag),  xfer_bu,  32'(m_xfer[1]));
`endif
    model_update(0, v, q, r, g_rr);
    model_update(1, v, q, r, g_bu);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic [nr-1:0] val;
    logic          rdy;
    int            exp_rr;
    int            exp_bu;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic r, input logic [nr-1:0] v, input logic q,
                     input int er, input int eb);
    vec_t t;
    t.rst = r; t.val = v; t.rdy = q; t.exp_rr = er; t.exp_bu = eb;
    tab.push_back(t);
  endtask

  initial begin
    // reset held two cycles with every requester valid
    add(1, 4'b1111, 1, -1, -1);
    add(1, 4'b1111, 1, -1, -1);
    // round-robin vs burst-of-3 with all valid
    add(0, 4'b1111, 1, 0, 0);
    add(0, 4'b1111, 1, 1, 0);
    add(0, 4'b1111, 1, 2, 0);
    add(0, 4'b1111, 1, 3, 1);
    add(0, 4'b1111, 1, 0, 1);
    add(0, 4'b1111, 1, 1, 1);
    add(0, 4'b1111, 1, 2, 2);
    add(0, 4'b1111, 1, 3, 2);
    // backpressure mid-burst: burst count must hold
    for (int i = 0; i < 5; i++) add(0, 4'b1111, 0, -1, -1);
    add(0, 4'b1111, 1, 0, 2);
    add(0, 4'b1111, 1, 1, 3);
    // drive rr pointer to 3, then wrap and skip with 0101
    add(0, 4'b0100, 1, 2, 2);
    add(0, 4'b0101, 1, 0, 2);
    add(0, 4'b0101, 1, 2, 2);
    add(0, 4'b0101, 1, 0, 0);
    // burst pattern 0,0,0,1,1,1,0 from a fresh reset
    add(1, 4'b0011, 1, -1, -1);
    add(0, 4'b0011, 1, 0, 0);
    add(0, 4'b0011, 1, 1, 0);
    add(0, 4'b0011, 1, 0, 0);
    add(0, 4'b0011, 1, 1, 1);
    add(0, 4'b0011, 1, 0, 1);
    add(0, 4'b0011, 1, 1, 1);
    add(0, 4'b0011, 1, 0, 0);
    // owner 0 drops after its second grant: lock breaks to 1 in the same cycle
    add(0, 4'b0011, 1, 1, 0);
    add(0, 4'b0010, 1, 1, 1);
    // lock onto owner 2, then reset mid-burst: search restarts at 0
    add(0, 4'b0100, 1, 2, 2);
    add(1, 4'b1111, 1, -1, -1);
    add(0, 4'b1111, 1, 0, 0);
    // idle and stalled cycles with a broken lock
    add(0, 4'b0000, 1, -1, -1);
    add(0, 4'b0010, 0, -1, -1);

    for (int i = 0; i < tab.size(); i++)
      step(tab[i].rst, tab[i].val, tab[i].rdy, 1'b1, tab[i].exp_rr, tab[i].exp_bu, i);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic r, q;
      logic [nr-1:0] v;
      r = ($urandom_range(0, 49) == 0);
      v = nr'($urandom_range(0, 15));
      q = ($urandom_range(0, 3) != 0);
      step(r, v, q, 1'b0, -1, -1, 1000 + i);
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
